mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage plus MEM/WB register; consumes the EX/MEM register outputs.
//  - Performs data-memory read/write on a word RAM with a parameterised access latency.
//  - Raises stall while an access is in flight.
//  - Resolves branches (PCSrc) and registers results for WB.
// PARAMETERS
//  ADDR_W   8  word-address width; RAM depth = 2**ADDR_W words of 32 bits
//  MEM_LAT  2  extra wait cycles per load/store (0 = single-cycle access)
// PORTS
//  clk            in   1   clock; all state on posedge
//  rst            in   1   asynchronous, active-high reset
//  MEM_Flag       in   5   {MemtoReg,MemRead,MemWrite,Branch,RegWrite}
//  MEM_WriteReg   in   5   destination register
//  MEM_ALUResult  in   32  byte address for load/store; result for R-type
//  MEM_ALUResultPC in  32  branch target
//  MEM_ReaddData2 in   32  store data
//  MEM_ZeroFlag   in   1   ALU zero
//  PCSrc          out  1   take-branch, combinational
//  BranchTarget   out  32  = MEM_ALUResultPC, combinational
//  stall          out  1   hold PC, IF/ID, ID/EX and EX/MEM; combinational from state
//  WB_Flag        out  2   {MemtoReg,RegWrite}, registered
//  WB_WriteReg    out  5   registered
//  WB_ALUResult   out  32  registered
//  WB_ReadData    out  32  registered load data
//  mem_fault      out  1   sticky misalignment flag (MEM_ALIGN_CHECK_EN only; else tied 0)
// BEHAVIOUR
//  Reset
//  - rst=1 clears state to IDLE, cnt=0, WB_Flag=0, WB_WriteReg=0, WB_ALUResult=0, WB_ReadData=0, mem_fault=0.
//  - stall=0 and PCSrc=0 while rst=1. RAM contents are not cleared; simulation init is all-zero.
//  - Reset asserted mid-access aborts it; a pending store is never written.
//  Addressing
//  - Word index = MEM_ALUResult[ADDR_W+1:2]. Upper bits are ignored: the address wraps modulo depth.
//  Access
//  - acc = MemRead|MemWrite.
//  - MemRead and MemWrite both set: store is performed; WB_ReadData returns the pre-write word (read-before-write).
//  FSM states: IDLE, BUSY.
//  - IDLE, acc=0: no stall; the WB register captures inputs at the next edge (1-cycle latency).
//  - IDLE, acc=1, MEM_LAT=0: access completes at this edge; no stall.
//  - IDLE, acc=1, MEM_LAT>0: stall=1; go to BUSY with cnt<=MEM_LAT-1; WB gets a bubble.
//  - BUSY, cnt!=0: stall=1; cnt decrements; WB gets a bubble.
//  - BUSY, cnt==0: stall=0; access completes at this edge; go to IDLE.
//  - Total stall = MEM_LAT cycles per access.
//  - Inputs are held stable by upstream while stall=1. Back-to-back accesses re-enter BUSY from IDLE.
//  Completion edge
//  - Store writes RAM[idx] <= MEM_ReaddData2.
//  - WB_ReadData <= RAM[idx]; WB_Flag/WB_WriteReg/WB_ALUResult <= inputs.
//  Bubble
//  - WB_Flag <= 2'b00; other WB registers hold their value.
//  Branch
//  - PCSrc = Branch & MEM_ZeroFlag & ~stall & ~rst.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined
//  - acc with MEM_ALUResult[1:0]!=0 sets mem_fault, sticky until rst.
//  - The store is suppressed; a load returns 32'h0.
//  - Timing and stall are unchanged.
//  MEM_ALIGN_CHECK_EN undefined
//  - Address bits [1:0] are ignored; mem_fault is tied 0.
// TESTING
//  1. rst pulse mid-BUSY (MEM_LAT=2) with a store pending -> stall drops in the same cycle, WB outputs 0, RAM word unchanged.
//  2. Store 32'hDEADBEEF to addr 0x10, then load 0x10, MEM_LAT=2 -> stall high 2 cycles each; WB_ReadData=32'hDEADBEEF, WB_Flag=2'b11.
//  3. R-type, ALUResult=32'h55, RegWrite=1, WriteReg=5'd7 -> next cycle WB_ALUResult=32'h55, WB_WriteReg=7, stall never high.
//  4. Branch=1, Zero=1, ALUResultPC=32'h40 -> PCSrc=1, BranchTarget=32'h40 in the same cycle; with Zero=0 -> PCSrc=0.
//  5. ADDR_W=8, store to byte addr 0x400 then load 0x0 -> same word returned (wrap); MEM_LAT=0 -> no stall cycles.
//  6. MEM_ALIGN_CHECK_EN: store to 0x13 -> mem_fault=1 and stays 1; RAM[4] unchanged; load 0x13 -> WB_ReadData=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage plus MEM/WB register.
//   Runs the data-memory load/store on a word RAM whose access takes MEM_LAT
//   extra cycles, raises stall while an access is in flight, resolves the
//   branch decision and registers results for WB.
//
// Parameters: ADDR_W  word-address width (RAM depth 2**ADDR_W x 32)
//             MEM_LAT extra wait cycles per load/store (0 = single cycle)
// Ports:
//   clk, rst                 clock, async active-high reset
//   MEM_Flag[4:0]            {MemtoReg,MemRead,MemWrite,Branch,RegWrite}
//   MEM_WriteReg[4:0]        destination register
//   MEM_ALUResult[31:0]      byte address (ld/st) or R-type result
//   MEM_ALUResultPC[31:0]    branch target
//   MEM_ReaddData2[31:0]     store data
//   MEM_ZeroFlag             ALU zero
//   PCSrc, BranchTarget      branch decision / target (combinational)
//   stall                    hold upstream stages (combinational from state)
//   WB_Flag[1:0]             {MemtoReg,RegWrite}, registered
//   WB_WriteReg, WB_ALUResult, WB_ReadData   registered
//   mem_fault                sticky misalignment flag
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned accesses fault,
//   stores suppressed, loads return 0). Undefined: mem_fault tied 0.
module mem_stage #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  MEM_Flag,
  input  logic [4:0]  MEM_WriteReg,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_ALUResultPC,
  input  logic [31:0] MEM_ReaddData2,
  input  logic        MEM_ZeroFlag,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic        stall,
  output logic [1:0]  WB_Flag,
  output logic [4:0]  WB_WriteReg,
  output logic [31:0] WB_ALUResult,
  output logic [31:0] WB_ReadData,
  output logic        mem_fault
);
  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               complete;
  logic               bad;

  logic mem_to_reg, mem_read, mem_write, branch, reg_write, acc;
  assign {mem_to_reg, mem_read, mem_write, branch, reg_write} = MEM_Flag;
  assign acc = mem_read | mem_write;

  logic [ADDR_W-1:0] idx;
  assign idx = MEM_ALUResult[ADDR_W+1:2];

  // Upper address bits wrap away; low bits only matter for the align check.
  logic unused_addr;
  assign unused_addr = ^{MEM_ALUResult[31:ADDR_W+2], MEM_ALUResult[1:0]};

  logic [31:0] ram [0:(1<<ADDR_W)-1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (acc && MEM_LAT > 0) begin
        state_nxt = BUSY;
        cnt_nxt   = CNT_W'(MEM_LAT - 1);
      end
      BUSY: if (cnt != '0) cnt_nxt = cnt - 1'b1;
            else           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: stall while waiting, complete on the final access edge.
  // Both are forced low in reset so an aborted store never lands.
  always_comb begin
    stall    = 1'b0;
    complete = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: if (acc) begin
          if (MEM_LAT == 0) complete = 1'b1;
          else              stall    = 1'b1;
        end
        BUSY: if (cnt != '0) stall    = 1'b1;
              else           complete = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign bad = acc & (MEM_ALUResult[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      mem_fault <= 1'b0;
    else if (bad) mem_fault <= 1'b1;
  end
`else
  assign bad       = 1'b0;
  assign mem_fault = 1'b0;
`endif

  // RAM write port; the WB read below samples the pre-write word.
  always_ff @(posedge clk) begin
    if (complete && mem_write && !bad) ram[idx] <= MEM_ReaddData2;
  end

  // MEM/WB register: a stalled cycle sends a bubble (flags cleared only).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_Flag      <= '0;
      WB_WriteReg  <= '0;
      WB_ALUResult <= '0;
      WB_ReadData  <= '0;
    end else if (stall) begin
      WB_Flag      <= 2'b00;
    end else begin
      WB_Flag      <= {mem_to_reg, reg_write};
      WB_WriteReg  <= MEM_WriteReg;
      WB_ALUResult <= MEM_ALUResult;
      if (complete) WB_ReadData <= bad ? 32'h0 : ram[idx];
    end
  end

  assign PCSrc        = branch & MEM_ZeroFlag & ~stall & ~rst;
  assign BranchTarget = MEM_ALUResultPC;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  MEM_Flag, MEM_WriteReg;
  logic [31:0] MEM_ALUResult, MEM_ALUResultPC, MEM_ReaddData2;
  logic        MEM_ZeroFlag;

  // dut: MEM_LAT=2; dz: MEM_LAT=0 (shared inputs)
  logic        PCSrc, stall, mem_fault;
  logic [31:0] BranchTarget, WB_ALUResult, WB_ReadData;
  logic [1:0]  WB_Flag;
  logic [4:0]  WB_WriteReg;
  logic        z_PCSrc, z_stall, z_mem_fault;
  logic [31:0] z_BranchTarget, z_WB_ALUResult, z_WB_ReadData;
  logic [1:0]  z_WB_Flag;
  logic [4:0]  z_WB_WriteReg;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(8), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .MEM_Flag(MEM_Flag), .MEM_WriteReg(MEM_WriteReg),
    .MEM_ALUResult(MEM_ALUResult), .MEM_ALUResultPC(MEM_ALUResultPC),
    .MEM_ReaddData2(MEM_ReaddData2), .MEM_ZeroFlag(MEM_ZeroFlag),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .stall(stall),
    .WB_Flag(WB_Flag), .WB_WriteReg(WB_WriteReg), .WB_ALUResult(WB_ALUResult),
    .WB_ReadData(WB_ReadData), .mem_fault(mem_fault));

  mem_stage #(.ADDR_W(8), .MEM_LAT(0)) dz (
    .clk(clk), .rst(rst), .MEM_Flag(MEM_Flag), .MEM_WriteReg(MEM_WriteReg),
    .MEM_ALUResult(MEM_ALUResult), .MEM_ALUResultPC(MEM_ALUResultPC),
    .MEM_ReaddData2(MEM_ReaddData2), .MEM_ZeroFlag(MEM_ZeroFlag),
    .PCSrc(z_PCSrc), .BranchTarget(z_BranchTarget), .stall(z_stall),
    .WB_Flag(z_WB_Flag), .WB_WriteReg(z_WB_WriteReg), .WB_ALUResult(z_WB_ALUResult),
    .WB_ReadData(z_WB_ReadData), .mem_fault(z_mem_fault));

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [4:0]  flag;
    logic [4:0]  wreg;
    logic [31:0] alu, pc, wd;
    logic        zero;
    int          nstall;
    logic        pcsrc;
    logic [31:0] rd;
    logic        chk_rd;
  } vec_t;

  typedef struct {
    string       name;
    logic [1:0]  wbflag;
    logic [4:0]  wreg;
    logic [31:0] alu, rd;
    logic        chk_rd;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [4:0] f, input logic [4:0] r,
                              input logic [31:0] a, input logic [31:0] pc, input logic [31:0] wd,
                              input logic z, input int ns, input logic ps,
                              input logic [31:0] rd, input logic ck);
    vec_t v;
    v.name = n; v.flag = f; v.wreg = r; v.alu = a; v.pc = pc; v.wd = wd;
    v.zero = z; v.nstall = ns; v.pcsrc = ps; v.rd = rd; v.chk_rd = ck;
    return v;
  endfunction

  task automatic drive(input logic [4:0] f, input logic [4:0] r, input logic [31:0] a,
                       input logic [31:0] pc, input logic [31:0] wd, input logic z);
    MEM_Flag = f; MEM_WriteReg = r; MEM_ALUResult = a;
    MEM_ALUResultPC = pc; MEM_ReaddData2 = wd; MEM_ZeroFlag = z;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the completion edge.
  task automatic run_vec(input vec_t v);
    int   nst;
    exp_t e, got;
    drive(v.flag, v.wreg, v.alu, v.pc, v.wd, v.zero);
    e.name = v.name; e.wbflag = {v.flag[4], v.flag[0]}; e.wreg = v.wreg;
    e.alu = v.alu; e.rd = v.rd; e.chk_rd = v.chk_rd;
    sb.push_back(e);
    @(negedge clk);
    chk({v.name, ".pcsrc"}, {31'b0, PCSrc}, {31'b0, v.pcsrc});
    chk({v.name, ".btarget"}, BranchTarget, v.pc);
    nst = 0;
    while (stall && nst < 20) begin
      nst++;
      @(posedge clk); #1;
      if (nst == 1) chk({v.name, ".bubble"}, {30'b0, WB_Flag}, 32'h0);
      @(negedge clk);
    end
    chk({v.name, ".nstall"}, nst, v.nstall);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk({v.name, ".sb_empty"}, 32'h1, 32'h0);
    end else begin
      got = sb.pop_front();
      chk({got.name, ".wbflag"}, {30'b0, WB_Flag}, {30'b0, got.wbflag});
      chk({got.name, ".wreg"}, {27'b0, WB_WriteReg}, {27'b0, got.wreg});
      chk({got.name, ".alu"}, WB_ALUResult, got.alu);
      if (got.chk_rd) chk({got.name, ".rd"}, WB_ReadData, got.rd);
    end
  endtask

  initial begin
    int mis_idx;
    vecs.push_back(mk("st_beef", 5'b00100, 5'd1, 32'h10, 32'h100, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("ld_beef", 5'b11001, 5'd2, 32'h10, 32'h0, 32'h0, 1'b0, 2, 1'b0, 32'hDEADBEEF, 1'b1));
    vecs.push_back(mk("rtype",   5'b00001, 5'd7, 32'h55, 32'h0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("br_tk",   5'b00010, 5'd0, 32'h0, 32'h40, 32'h0, 1'b1, 0, 1'b1, 32'h0, 1'b0));
    vecs.push_back(mk("br_nt",   5'b00010, 5'd0, 32'h0, 32'h40, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("rt_zero", 5'b00001, 5'd9, 32'hABC, 32'h80, 32'h0, 1'b1, 0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("st_wrap", 5'b00100, 5'd3, 32'h400, 32'h0, 32'h12345678, 1'b0, 2, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("ld_wrap", 5'b11001, 5'd4, 32'h0, 32'h0, 32'h0, 1'b0, 2, 1'b0, 32'h12345678, 1'b1));
    vecs.push_back(mk("st_24",   5'b00100, 5'd5, 32'h24, 32'h0, 32'h0BADF00D, 1'b0, 2, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("rmw_24",  5'b11101, 5'd6, 32'h24, 32'h0, 32'hA5A5A5A5, 1'b0, 2, 1'b0, 32'h0BADF00D, 1'b1));
    vecs.push_back(mk("ld_24",   5'b11001, 5'd8, 32'h24, 32'h0, 32'h0, 1'b0, 2, 1'b0, 32'hA5A5A5A5, 1'b1));
    mis_idx = vecs.size();
    vecs.push_back(mk("st_mis",  5'b00100, 5'd10, 32'h13, 32'h0, 32'h77, 1'b0, 2, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk("ld_w4",   5'b11001, 5'd11, 32'h10, 32'h0, 32'h0, 1'b0, 2, 1'b0,
                      FAULT_EN ? 32'hDEADBEEF : 32'h77, 1'b1));
    vecs.push_back(mk("ld_mis",  5'b11001, 5'd12, 32'h13, 32'h0, 32'h0, 1'b0, 2, 1'b0,
                      FAULT_EN ? 32'h0 : 32'h77, 1'b1));
    vecs.push_back(mk("rt_after", 5'b00001, 5'd13, 32'h99, 32'h0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0));

    // Reset state, with a taken branch presented during reset.
    rst = 1'b1;
    drive(5'b00010, 5'd0, 32'h0, 32'h40, 32'h0, 1'b1);
    #3;
    chk("rst.stall", {31'b0, stall}, 32'h0);
    chk("rst.pcsrc", {31'b0, PCSrc}, 32'h0);
    chk("rst.wbflag", {30'b0, WB_Flag}, 32'h0);
    chk("rst.wreg", {27'b0, WB_WriteReg}, 32'h0);
    chk("rst.alu", WB_ALUResult, 32'h0);
    chk("rst.rd", WB_ReadData, 32'h0);
    chk("rst.fault", {31'b0, mem_fault}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    drive(5'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    // MEM_LAT=0 instance: single-cycle store then load through a wrapped address.
    drive(5'b00100, 5'd0, 32'h400, 32'h0, 32'h9ABCDEF0, 1'b0);
    @(negedge clk);
    chk("z_st.stall", {31'b0, z_stall}, 32'h0);
    @(posedge clk); #1;
    drive(5'b11001, 5'd13, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("z_ld.stall", {31'b0, z_stall}, 32'h0);
    @(posedge clk); #1;
    chk("z_ld.rd", z_WB_ReadData, 32'h9ABCDEF0);
    chk("z_ld.wbflag", {30'b0, z_WB_Flag}, 32'h3);
    chk("z_ld.wreg", {27'b0, z_WB_WriteReg}, 32'd13);
    // The LAT=2 instance saw an illegal input change above; reset both.
    drive(5'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Main vector table on the MEM_LAT=2 instance.
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
      chk({vecs[i].name, ".fault"}, {31'b0, mem_fault},
          {31'b0, (FAULT_EN && i >= mis_idx)});
    end

    // Reset mid-BUSY with a store pending: the store must never land.
    run_vec(mk("st_20", 5'b00100, 5'd14, 32'h20, 32'h0, 32'h11111111, 1'b0, 2, 1'b0, 32'h0, 1'b0));
    drive(5'b00100, 5'd15, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    chk("rbusy.stall0", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rbusy.stall1", {31'b0, stall}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("rbusy.stall", {31'b0, stall}, 32'h0);
    chk("rbusy.wbflag", {30'b0, WB_Flag}, 32'h0);
    chk("rbusy.alu", WB_ALUResult, 32'h0);
    chk("rbusy.rd", WB_ReadData, 32'h0);
    chk("rbusy.fault", {31'b0, mem_fault}, 32'h0);
    @(posedge clk); #1;
    drive(5'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(mk("ld_20", 5'b11001, 5'd16, 32'h20, 32'h0, 32'h0, 1'b0, 2, 1'b0, 32'h11111111, 1'b1));

    chk("sb.drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
